// File: rtl/c5_mem_bus_bridge_pkg.sv
// c5_mem_bus_bridge_pkg: shared state encodings and constants for the bus bridge
package c5_mem_bus_bridge_pkg;
  typedef enum logic {
    BRIDGE_IDLE = 1'b0,
    BRIDGE_BUSY = 1'b1
  } bridge_state_t;
  localparam logic [31:0] ZERO     = 32'h0;
  localparam logic [3:0]  NO_WRITE = 4'b0000;
endpackage

// File: rtl/c5_bus_timeout.sv
// c5_bus_timeout: loadable up-counter with clear, enable and terminal-count flag
// Ports:
//   I_clk, I_rst_n   clock, asynchronous active-low reset
//   I_clr            synchronous clear to zero (highest priority)
//   I_load           load I_load_val
//   I_en             increment by one
//   I_load_val       value loaded when I_load=1
//   O_tc             high while the count equals TERMINAL
module c5_bus_timeout #(
  parameter int W        = 8,
  parameter int TERMINAL = 254
) (
  input  logic         I_clk,
  input  logic         I_rst_n,
  input  logic         I_clr,
  input  logic         I_load,
  input  logic         I_en,
  input  logic [W-1:0] I_load_val,
  output logic         O_tc
);
  logic [W-1:0] r_count;
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)    r_count <= '0;
    else if (I_clr)  r_count <= '0;
    else if (I_load) r_count <= I_load_val;
    else if (I_en)   r_count <= r_count + W'(1);
  end
  assign O_tc = r_count == W'(TERMINAL);
endmodule

// File: rtl/c5_mem_bus_bridge.sv
// c5_mem_bus_bridge: turns the single-cycle RAM port into a req/ack bus transaction with CPU pause
// Ports:
//   I_clk, I_rst_n                      clock, asynchronous active-low reset
//   I_address_next/I_byte_we_next/I_data_w  next access from the memory controller
//   I_pause_ext                         external stall; blocks capture of a new access
//   O_data_r                            registered read data
//   O_pause                             stall to the CPU while a transaction is outstanding
//   O_bus_req/O_bus_addr/O_bus_we/O_bus_wdata  registered bus request and payload
//   I_bus_ack/I_bus_rdata               slave completion and read data
//   O_bus_err/O_err_sticky              timeout pulse and sticky timeout flag
module c5_mem_bus_bridge
  import c5_mem_bus_bridge_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic [29:0]      I_address_next,
  input  logic [3:0]       I_byte_we_next,
  input  logic [WIDTH-1:0] I_data_w,
  input  logic             I_pause_ext,
  output logic [WIDTH-1:0] O_data_r,
  output logic             O_pause,
  output logic             O_bus_req,
  output logic [29:0]      O_bus_addr,
  output logic [3:0]       O_bus_we,
  output logic [WIDTH-1:0] O_bus_wdata,
  input  logic             I_bus_ack,
  input  logic [WIDTH-1:0] I_bus_rdata,
  output logic             O_bus_err,
  output logic             O_err_sticky
);
  localparam int CW = $clog2(TIMEOUT + 1);
  bridge_state_t r_state, w_state_nxt;
  logic w_capture, w_done_ack, w_done_to, w_cnt_en, w_tc;
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) r_state <= BRIDGE_IDLE;
    else          r_state <= w_state_nxt;
  end
  // An ack wins over an expiring counter on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done_ack  = 1'b0;
    w_done_to   = 1'b0;
    w_cnt_en    = 1'b0;
    if (r_state == BRIDGE_IDLE) begin
      w_capture   = !I_pause_ext;
      w_state_nxt = I_pause_ext ? BRIDGE_IDLE : BRIDGE_BUSY;
    end else begin
      w_done_ack  = I_bus_ack;
      w_done_to   = !I_bus_ack && w_tc;
      w_cnt_en    = !I_bus_ack && !w_tc;
      w_state_nxt = (I_bus_ack || w_tc) ? BRIDGE_IDLE : BRIDGE_BUSY;
    end
  end
  assign O_pause = r_state == BRIDGE_BUSY;
  c5_bus_timeout #(.W(CW), .TERMINAL(TIMEOUT - 1)) u_timeout (
    .I_clk      (I_clk),
    .I_rst_n    (I_rst_n),
    .I_clr      (w_capture),
    .I_load     (1'b0),
    .I_en       (w_cnt_en),
    .I_load_val ({CW{1'b0}}),
    .O_tc       (w_tc)
  );
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_bus_req    <= 1'b0;
      O_bus_addr   <= '0;
      O_bus_we     <= NO_WRITE;
      O_bus_wdata  <= '0;
      O_data_r     <= '0;
      O_bus_err    <= 1'b0;
      O_err_sticky <= 1'b0;
    end else begin
      O_bus_err <= w_done_to;
      if (w_done_to) O_err_sticky <= 1'b1;
      if (w_capture) begin
        O_bus_req   <= 1'b1;
        O_bus_addr  <= I_address_next;
        O_bus_we    <= I_byte_we_next;
        O_bus_wdata <= I_data_w;
      end else if (w_done_ack || w_done_to) begin
        O_bus_req <= 1'b0;
      end
      // Writes leave the last read data untouched; timed-out reads return zero.
      if (O_bus_we == NO_WRITE && w_done_ack) O_data_r <= I_bus_rdata;
      else if (O_bus_we == NO_WRITE && w_done_to) O_data_r <= ZERO[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_c5_mem_bus_bridge.sv
// tb_c5_mem_bus_bridge: randomized self-checking bench against a transaction-level model
module tb_c5_mem_bus_bridge;
  localparam int TO = 8;
  logic        I_clk, I_rst_n, I_pause_ext, I_bus_ack;
  logic [29:0] I_address_next, O_bus_addr;
  logic [3:0]  I_byte_we_next, O_bus_we;
  logic [31:0] I_data_w, O_data_r, O_bus_wdata, I_bus_rdata;
  logic        O_pause, O_bus_req, O_bus_err, O_err_sticky;
  int n_chk = 0, n_pass = 0;
  logic [31:0] exp_data = 0;
  logic        exp_sticky = 0;
  c5_mem_bus_bridge #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_address_next(I_address_next),
    .I_byte_we_next(I_byte_we_next), .I_data_w(I_data_w), .I_pause_ext(I_pause_ext),
    .O_data_r(O_data_r), .O_pause(O_pause), .O_bus_req(O_bus_req), .O_bus_addr(O_bus_addr),
    .O_bus_we(O_bus_we), .O_bus_wdata(O_bus_wdata), .I_bus_ack(I_bus_ack),
    .I_bus_rdata(I_bus_rdata), .O_bus_err(O_bus_err), .O_err_sticky(O_err_sticky)
  );
  initial I_clk = 0;
  always #5 I_clk = ~I_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic chk_idle_regs();
    chk("rst_req", O_bus_req, 0);
    chk("rst_pause", O_pause, 0);
    chk("rst_addr", O_bus_addr, 0);
    chk("rst_we", O_bus_we, 0);
    chk("rst_wdata", O_bus_wdata, 0);
    chk("rst_data", O_data_r, 0);
    chk("rst_err", O_bus_err, 0);
    chk("rst_sticky", O_err_sticky, 0);
  endtask
  // ackd = BUSY cycle index at which ack is presented; ackd >= TO means never.
  task automatic run_txn(input logic [29:0] a, input logic [3:0] we, input logic [31:0] wd,
                         input int npause, input int ackd, input logic [31:0] rd);
    int  busy;
    bit  tmo;
    I_address_next = a; I_byte_we_next = we; I_data_w = wd; I_pause_ext = 1;
    repeat (npause) begin
      I_bus_ack = 1'($urandom_range(0, 1)); I_bus_rdata = $urandom;
      @(negedge I_clk);
      chk("held_req", O_bus_req, 0);
      chk("held_pause", O_pause, 0);
      chk("held_data", O_data_r, exp_data);
    end
    I_bus_ack = 1'($urandom_range(0, 1)); I_bus_rdata = $urandom; I_pause_ext = 0;
    @(negedge I_clk);
    I_pause_ext = 1; I_address_next = 30'($urandom); I_byte_we_next = 4'($urandom); I_data_w = $urandom;
    busy = 0;
    while (O_pause && busy < 20) begin
      chk("busy_req", O_bus_req, 1);
      chk("busy_addr", O_bus_addr, a);
      chk("busy_we", O_bus_we, we);
      chk("busy_wdata", O_bus_wdata, wd);
      chk("busy_data", O_data_r, exp_data);
      I_bus_ack = busy == ackd;
      I_bus_rdata = I_bus_ack ? rd : $urandom;
      busy++;
      @(negedge I_clk);
    end
    I_bus_ack = 0;
    tmo = ackd >= TO;
    if (we == 4'b0000) exp_data = tmo ? 32'h0 : rd;
    exp_sticky |= tmo;
    chk("busy_cycles", busy, tmo ? TO : ackd + 1);
    chk("done_req", O_bus_req, 0);
    chk("done_data", O_data_r, exp_data);
    chk("done_err", O_bus_err, tmo);
    chk("done_sticky", O_err_sticky, exp_sticky);
    @(negedge I_clk);
    chk("err_pulse", O_bus_err, 0);
    chk("no_dup_req", O_bus_req, 0);
  endtask
  initial begin
    I_rst_n = 0; I_pause_ext = 1; I_bus_ack = 0; I_bus_rdata = 0;
    I_address_next = 0; I_byte_we_next = 0; I_data_w = 0;
    #2;
    chk_idle_regs();
    @(negedge I_clk); @(negedge I_clk);
    I_rst_n = 1;
    @(negedge I_clk);
    chk_idle_regs();
    run_txn(30'h100, 4'b0000, 32'h0, 0, 0, 32'hCAFEF00D);
    run_txn(30'h3FF, 4'b1100, 32'h12341234, 0, 5, 32'hDEADBEEF);
    run_txn(30'h2A, 4'b1111, 32'hA5A5A5A5, 4, 1, 32'h0);
    run_txn(30'h55, 4'b0000, 32'h0, 1, TO, 32'h11111111);
    run_txn(30'h77, 4'b0000, 32'h0, 0, TO - 1, 32'h55AA55AA);
    run_txn(30'h78, 4'b0011, 32'h0F0F0F0F, 0, TO + 2, 32'h0);
    for (int i = 0; i < 40; i++)
      run_txn(30'($urandom), $urandom_range(0, 1) ? 4'($urandom) : 4'b0000, $urandom,
              $urandom_range(0, 3), $urandom_range(0, TO + 2), $urandom);
    I_address_next = 30'h1234; I_byte_we_next = 4'b0001; I_data_w = 32'hFEEDFACE; I_pause_ext = 0;
    @(negedge I_clk);
    I_pause_ext = 1;
    chk("pre_rst_pause", O_pause, 1);
    #2 I_rst_n = 0;
    #1;
    exp_data = 0; exp_sticky = 0;
    chk_idle_regs();
    @(negedge I_clk);
    I_rst_n = 1;
    @(negedge I_clk);
    chk_idle_regs();
    run_txn(30'h3C, 4'b0000, 32'h0, 0, 2, 32'h600DF00D);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/c5_mem_bus_bridge.md
Name: c5_mem_bus_bridge

Overview:
Sits directly downstream of the CPU memory controller. It replaces the single-cycle synchronous RAM port with a request/acknowledge bus to slow memory or peripherals. It latches the controller's next-cycle address, byte enables and write data, then runs one bus transaction per access. While the transaction is outstanding it asserts pause back into the CPU, and it returns registered read data. A watchdog completes any transaction that is never acknowledged.

Parameters:
WIDTH, 32, data bus width in bits; only 32 is supported.
TIMEOUT, 255, maximum number of BUSY cycles before forced completion; legal range 1..65535.

Ports:
I_clk  input  1  clock, rising edge
I_rst_n  input  1  asynchronous active-low reset
I_address_next  input  30  word address [31:2] from the memory controller for the coming access
I_byte_we_next  input  4  byte write enables; 0000 means read
I_data_w  input  32  write data, aligned and replicated by the memory controller
I_pause_ext  input  1  pause from other CPU sources; blocks capture of a new access
O_data_r  output  32  registered read data to the memory controller
O_pause  output  1  stall request to the CPU pipeline
O_bus_req  output  1  bus request, registered, held until acknowledged
O_bus_addr  output  30  registered word address
O_bus_we  output  4  registered byte enables
O_bus_wdata  output  32  registered write data
I_bus_ack  input  1  slave completion, sampled at the rising edge of I_clk
I_bus_rdata  input  32  read data, valid when I_bus_ack=1
O_bus_err  output  1  one-cycle pulse when a timeout completes an access
O_err_sticky  output  1  set on any timeout; cleared only by reset

Behaviour:
- Reset (asynchronous, active-low) forces the following, immediately and regardless of the clock:
  - state=IDLE, O_bus_req=0, O_bus_addr=0, O_bus_we=0000, O_bus_wdata=0, O_data_r=0;
  - O_bus_err=0, O_err_sticky=0, timeout counter=0.
- Reset during BUSY abandons the transaction: req drops with no completion and the slave must tolerate this. Leaving reset, the bridge starts in IDLE.
- The state machine has two states, IDLE and BUSY.
- IDLE, O_pause=0:
  - At a clock edge with I_pause_ext=0, capture I_address_next, I_byte_we_next and I_data_w into the O_bus_* registers.
  - In the same edge, set O_bus_req=1, clear the counter and go to BUSY.
  - With I_pause_ext=1, no capture occurs and the state stays IDLE. This prevents duplicate writes while the CPU is frozen.
- BUSY, O_pause=1 (combinational from state):
  - Edge with I_bus_ack=1:
    - if O_bus_we=0000, O_data_r<=I_bus_rdata; for writes O_data_r holds its previous value;
    - O_bus_req<=0; state<=IDLE.
  - Edge with I_bus_ack=0 and counter=TIMEOUT-1:
    - O_data_r<=0 for reads; O_bus_req<=0;
    - O_bus_err<=1 for one cycle; O_err_sticky<=1;
    - state<=IDLE.
  - Otherwise, increment the counter.
- Latency: capture edge, then a minimum of 1 BUSY cycle, then IDLE. The minimum access is therefore 2 cycles, and each slave wait cycle adds 1.
- An ack on the same edge as the timeout expiry counts as an ack: data is taken and no error is raised.
- I_bus_ack is ignored in IDLE and must not alter any output there.
- O_bus_addr, O_bus_we and O_bus_wdata are stable for the whole time O_bus_req=1.
- O_data_r is stable from completion until the next read completes.
- Back-to-back accesses: the capture in IDLE may occur on the edge immediately after completion, giving an ack-to-next-req gap of one edge.
- Counter width is ceil(log2(TIMEOUT+1)) bits and never wraps, because the state leaves BUSY at TIMEOUT-1.
- The bridge does not decode the address; all accesses go to the bus.

Decomposition:
- Add to c5_parameters.v: the state encodings BRIDGE_IDLE/BRIDGE_BUSY (1 bit), the constant ZERO (already present), and a NO_WRITE=4'b0000 constant.
- One sub-module is natural: c5_bus_timeout. It is a loadable up-counter with clear, enable and a terminal-count output, so other bus masters can reuse it.

Test Plan:
1. Reset check: reset released, I_pause_ext=0, address_next=0x100, we=0000; slave acks one cycle after req with rdata=0xCAFEF00D. Required: req high for exactly 1 cycle, O_pause high for 1 cycle, O_data_r=0xCAFEF00D afterwards, O_bus_err never set.
2. Wait states: write we=1100, data=0x12341234, addr=0x3FF; ack delayed 5 cycles. Required: O_pause high for 6 cycles, addr/we/wdata unchanged throughout, O_data_r unchanged.
3. External pause: hold I_pause_ext=1 for 4 cycles with we=1111. Required: O_bus_req stays 0. After release, exactly one write is issued.
4. Timeout: TIMEOUT=8, read with no ack. Required: O_pause high for 8 cycles, then a one-cycle O_bus_err pulse, O_err_sticky=1, O_data_r=0.
5. Simultaneous events: ack arrives on the same edge as counter=TIMEOUT-1, with rdata=0x55AA55AA. Required: data=0x55AA55AA and no error.
6. Asynchronous reset mid-BUSY: assert I_rst_n=0 between clock edges during BUSY. Required: O_bus_req=0 and O_pause=0 immediately; after release, O_bus_* are zero and the state is IDLE.
